// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial transmit sequencer.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

    // Ceiling log2; returns 0 for n<=1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_tx_shift_core.sv
// WIDTH-bit circular register: loads on 'load', otherwise rotates left every cycle.
module serial_tx_shift_core
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             load,
    input  logic [WIDTH-1:0] load_in,
    output logic             shift_out
);

    logic [WIDTH-1:0] r_shreg;

    // No reset here: the sequencer forces a load of zero while in reset.
    always_ff @(posedge clock) begin
        if (load) r_shreg <= load_in;
        else      r_shreg <= {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
    end

    assign shift_out = r_shreg[WIDTH-1];

endmodule

// File: rtl/serial_tx_sequencer.sv
// Serializes parallel words MSB-first with frame flags and a frame counter.
// Optional even-parity bit per frame when SERIAL_TX_PARITY_EN is defined.
module serial_tx_sequencer
    import serial_tx_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             shift_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy,
    output logic [7:0]       frames_sent
);

    localparam int CW = clog2(WIDTH);
    localparam int GW = (clog2(GAP_CYCLES + 1) < 1) ? 1 : clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_bit_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic [7:0]       r_frames;
    logic             w_handshake;
    logic             w_core_bit;
    logic             w_core_load;
    logic [WIDTH-1:0] w_core_data;
`ifdef SERIAL_TX_PARITY_EN
    logic             r_parity;
    logic             w_sel_par;
`endif

    assign w_handshake = in_valid & in_ready;
    assign w_core_load = reset | w_handshake;
    assign w_core_data = reset ? '0 : load_in;

    serial_tx_shift_core #(.WIDTH(WIDTH)) u_core (
        .clock     (clock),
        .load      (w_core_load),
        .load_in   (w_core_data),
        .shift_out (w_core_bit)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_frames  <= '0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            if (w_handshake) begin
                r_bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
                r_parity  <= ^load_in;
`endif
            end else if (r_state == SHIFT) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_state == GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
            else                r_gap_cnt <= '0;
            if (frame_done) r_frames <= r_frames + 8'd1;
        end
    end

    always_comb begin
        w_next      = r_state;
        in_ready    = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        frame_done  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        w_sel_par   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = SHIFT;
            end
            SHIFT: begin
                bit_valid   = 1'b1;
                frame_start = (r_bit_cnt == '0);
                if (r_bit_cnt == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                    w_next = PARITY;
`else
                    frame_done = 1'b1;
                    w_next     = (GAP_CYCLES > 0) ? GAP : IDLE;
`endif
                end
            end
            PARITY: begin
`ifdef SERIAL_TX_PARITY_EN
                bit_valid  = 1'b1;
                w_sel_par  = 1'b1;
                frame_done = 1'b1;
                w_next     = (GAP_CYCLES > 0) ? GAP : IDLE;
`else
                w_next = IDLE;
`endif
            end
            GAP: begin
                if (r_gap_cnt == LAST_GAP) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // After WIDTH rotations the core holds the word again, so it can idle-rotate freely.
`ifdef SERIAL_TX_PARITY_EN
    assign shift_out = bit_valid & (w_sel_par ? r_parity : w_core_bit);
`else
    assign shift_out = bit_valid & w_core_bit;
`endif
    assign busy        = (r_state != IDLE);
    assign frames_sent = r_frames;

endmodule

// File: tb/tb_serial_tx_sequencer.sv
// Scoreboard bench for serial_tx_sequencer; parity checks enabled with SERIAL_TX_PARITY_EN.
module tb_serial_tx_sequencer;

    localparam int W   = 16;
    localparam int GAP = 1;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed { logic b; logic s; logic d; } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] load_in, load_in0;
    logic         in_valid, in_valid0;
    logic         in_ready, shift_out, bit_valid, frame_start, frame_done, busy;
    logic [7:0]   frames_sent;
    logic         in_ready0, shift_out0, bit_valid0, frame_start0, frame_done0, busy0;
    logic [7:0]   frames_sent0;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    bit   mon_en = 0;
    int   cyc = 0;
    int   last_done = 0;
    int   last_gap = -1;

    always #5 clk = ~clk;

    serial_tx_sequencer #(.WIDTH(W), .GAP_CYCLES(GAP)) dut (
        .clock(clk), .reset(rst), .load_in(load_in), .in_valid(in_valid),
        .in_ready(in_ready), .shift_out(shift_out), .bit_valid(bit_valid),
        .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
        .frames_sent(frames_sent)
    );

    serial_tx_sequencer #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
        .clock(clk), .reset(rst), .load_in(load_in0), .in_valid(in_valid0),
        .in_ready(in_ready0), .shift_out(shift_out0), .bit_valid(bit_valid0),
        .frame_start(frame_start0), .frame_done(frame_done0), .busy(busy0),
        .frames_sent(frames_sent0)
    );

    // Scoreboard monitor: every valid bit must match the next expected entry.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            cyc++;
            if (frame_done === 1'b1) last_done = cyc;
            if (frame_start === 1'b1) last_gap = cyc - last_done - 1;
            n_chk++;
            if (bit_valid === 1'b1) begin
                if (q.size() == 0) begin
                    $display("FAIL unexpected_bit: got shift_out=%b with empty scoreboard", shift_out);
                end else begin
                    e = q.pop_front();
                    if ({shift_out, frame_start, frame_done} !== {e.b, e.s, e.d})
                        $display("FAIL serial_bit: got {bit,start,done}=%b%b%b expected %b%b%b",
                                 shift_out, frame_start, frame_done, e.b, e.s, e.d);
                    else n_pass++;
                end
            end else begin
                if ({bit_valid, shift_out, frame_start, frame_done} !== 4'b0000)
                    $display("FAIL idle_outputs: got {valid,bit,start,done}=%b%b%b%b expected 0000",
                             bit_valid, shift_out, frame_start, frame_done);
                else n_pass++;
            end
        end
    end

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            exp_t e;
            e.b = w[W-1-i];
            e.s = (i == 0);
            e.d = (PAR == 0) && (i == W - 1);
            q.push_back(e);
        end
        if (PAR != 0) begin
            exp_t e;
            e.b = ^w;
            e.s = 1'b0;
            e.d = 1'b1;
            q.push_back(e);
        end
    endtask

    // Presents a word, waits for the handshake edge; returns #1 after it.
    task automatic send_word(input logic [W-1:0] w, input bit hold);
        int t = 0;
        load_in  = w;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        n_chk++;
        if (t >= 200) $display("FAIL handshake_timeout: in_ready=%b expected 1", in_ready);
        else n_pass++;
        push_word(w);
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    // Returns at the negedge where frame_done is high.
    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (t >= 200) $display("FAIL done_timeout: frame_done=%b expected 1", frame_done);
        else n_pass++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; load_in = '0; in_valid0 = 1'b0; load_in0 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({in_ready, busy, bit_valid, shift_out, frame_start, frame_done, frames_sent} !== {6'b100000, 8'd0})
            $display("FAIL reset_state: got rdy/busy/vld/bit/st/dn=%b%b%b%b%b%b cnt=%0d expected 100000 cnt=0",
                     in_ready, busy, bit_valid, shift_out, frame_start, frame_done, frames_sent);
        else n_pass++;
        rst = 1'b0;
        mon_en = 1;
    endtask

    task automatic test_single();
        send_word(16'hA5C3, 0);
        wait_done();
        @(negedge clk);
        n_chk++;
        if ({in_ready, bit_valid, shift_out, busy, frames_sent} !== {4'b0001, 8'd1})
            $display("FAIL single_gap: got rdy/vld/bit/busy=%b%b%b%b cnt=%0d expected 0001 cnt=1",
                     in_ready, bit_valid, shift_out, busy, frames_sent);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({in_ready, busy} !== 2'b10)
            $display("FAIL single_idle: got rdy/busy=%b%b expected 10", in_ready, busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_word(16'hFFFF, 1);
        send_word(16'h0000, 0);
        load_in = 16'h5A5A;
        wait_done();
        @(negedge clk);
        n_chk++;
        if (frames_sent !== 8'd2) $display("FAIL b2b_count: got %0d expected 2", frames_sent);
        else n_pass++;
        n_chk++;
        if (last_gap != GAP + 1) $display("FAIL b2b_gap: got %0d non-bit cycles expected %0d", last_gap, GAP + 1);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        repeat (3) @(posedge clk);
        #1;
        send_word(16'h1234, 0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        q.delete();
        n_chk++;
        if ({in_ready, busy, bit_valid, shift_out, frame_start, frame_done, frames_sent} !== {6'b100000, 8'd0})
            $display("FAIL midframe_reset: got rdy/busy/vld/bit/st/dn=%b%b%b%b%b%b cnt=%0d expected 100000 cnt=0",
                     in_ready, busy, bit_valid, shift_out, frame_start, frame_done, frames_sent);
        else n_pass++;
        rst = 1'b0;
        send_word(16'hC0DE, 0);
        wait_done();
        @(negedge clk);
        n_chk++;
        if (frames_sent !== 8'd1) $display("FAIL midframe_recover: got %0d expected 1", frames_sent);
        else n_pass++;
    endtask

    task automatic test_parity();
        do_reset();
        send_word(16'h0001, 0);
        wait_done();
        send_word(16'h0003, 0);
        wait_done();
        @(negedge clk);
        n_chk++;
        if (frames_sent !== 8'd2) $display("FAIL parity_count: got %0d expected 2", frames_sent);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_word(W'($urandom), (i != 255));
            if (i == 255) begin
                n_chk++;
                if (frames_sent !== 8'd255) $display("FAIL wrap_255: got %0d expected 255", frames_sent);
                else n_pass++;
            end
        end
        wait_done();
        @(negedge clk);
        n_chk++;
        if (frames_sent !== 8'd0) $display("FAIL wrap_zero: got %0d expected 0", frames_sent);
        else n_pass++;
        n_chk++;
        if (q.size() != 0) $display("FAIL wrap_drain: got %0d pending bits expected 0", q.size());
        else n_pass++;
    endtask

    task automatic test_gap0();
        int done_c = -1;
        int start_c = -1;
        logic first_bit = 1'b0;
        load_in0  = 16'hAAAA;
        in_valid0 = 1'b1;
        for (int c = 0; c < 100 && start_c < 0; c++) begin
            @(negedge clk);
            if (frame_done0 === 1'b1 && done_c < 0) done_c = c;
            else if (frame_start0 === 1'b1 && done_c >= 0) begin
                start_c   = c;
                first_bit = shift_out0;
            end
        end
        in_valid0 = 1'b0;
        n_chk++;
        if (start_c < 0 || start_c - done_c - 1 != 1)
            $display("FAIL gap0_spacing: got %0d non-bit cycles expected 1", start_c - done_c - 1);
        else n_pass++;
        n_chk++;
        if (first_bit !== 1'b1) $display("FAIL gap0_msb: got %b expected 1", first_bit);
        else n_pass++;
        repeat (40) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_midframe();
`ifdef SERIAL_TX_PARITY_EN
        test_parity();
`endif
        test_wrap();
        test_gap0();
        @(negedge clk);
        n_chk++;
        if (q.size() != 0) $display("FAIL final_drain: got %0d pending bits expected 0", q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
